// File: rtl/qn_event_pkg.sv
// rtl/qn_event_pkg.sv - shared constants, layer codes and state encoding for event_reader
package qn_event_pkg;

    localparam int         WORDS_PER_EVENT = 32;
    localparam logic [7:0] NO_HIT          = 8'hFF;
    localparam int         TIMEOUT         = 1024;

    localparam logic [4:0] LAYER_3A = 5'b11000;
    localparam logic [4:0] LAYER_3B = 5'b11001;
    localparam logic [4:0] LAYER_4A = 5'b00100;
    localparam logic [4:0] LAYER_4B = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HOLD,
        ST_RESYNC
    } reader_state_t;

    // Header expected for word index idx: {layer code, tube}, eight tubes per layer
    function automatic logic [7:0] expected_hdr(input logic [4:0] idx);
        logic [4:0] code;
        case (idx[4:3])
            2'd0:    code = LAYER_3A;
            2'd1:    code = LAYER_3B;
            2'd2:    code = LAYER_4A;
            default: code = LAYER_4B;
        endcase
        return {code, idx[2:0]};
    endfunction

endpackage

// File: rtl/hdr_check.sv
// rtl/hdr_check.sv - compares a word header against the header expected at a word index
module hdr_check
    import qn_event_pkg::*;
(
    input  logic [4:0] idx,
    input  logic [7:0] hdr,
    output logic       match,
    output logic       is_index0
);

    assign match     = (hdr == expected_hdr(idx));
    assign is_index0 = (hdr == expected_hdr(5'd0));

endmodule

// File: rtl/event_reader.sv
// rtl/event_reader.sv - reassembles 32-word tube events from a 1-cycle-latency word FIFO
module event_reader #(
    parameter int         WORDS_PER_EVENT = qn_event_pkg::WORDS_PER_EVENT,
    parameter logic [7:0] NO_HIT          = qn_event_pkg::NO_HIT,
    parameter int         TIMEOUT         = qn_event_pkg::TIMEOUT
) (
    input  logic                         clk100,
    input  logic                         rst_n,
    input  logic                         RD_EMPTY,
    input  logic                         RD_VALID,
    input  logic [15:0]                  OTUBE,
    output logic                         RD_EN,
    output logic [8*WORDS_PER_EVENT-1:0] ev_data,
    output logic [WORDS_PER_EVENT-1:0]   ev_hits,
    output logic                         ev_valid,
    input  logic                         ev_ready,
    output logic                         err_seq,
    output logic [7:0]                   err_count
);
    import qn_event_pkg::*;

    localparam int IDX_W = $clog2(WORDS_PER_EVENT);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    reader_state_t    state;
    logic [IDX_W-1:0] recv_cnt;
    logic [TMO_W-1:0] idle_cnt;
    logic             pending;
    logic [7:0]       hdr;
    logic [7:0]       radius;
    logic             hdr_match;
    logic             hdr_index0;
    logic             word_ok;
    logic             stray_word;
    logic             timed_out;
    logic             err_now;
    logic             store_en;
    logic [IDX_W-1:0] store_slot;

    // OTUBE[4:0] layer code, OTUBE[7:5] tube, OTUBE[15:8] radius
    assign hdr    = {OTUBE[4:0], OTUBE[7:5]};
    assign radius = OTUBE[15:8];

    hdr_check u_hdr_check (
        .idx       (5'(recv_cnt)),
        .hdr       (hdr),
        .match     (hdr_match),
        .is_index0 (hdr_index0)
    );

    assign word_ok    = RD_VALID && pending;
    assign stray_word = RD_VALID && !pending;
    assign timed_out  = (state == ST_FILL) && (recv_cnt != '0) && !word_ok
                        && (idle_cnt == TMO_W'(TIMEOUT - 1));
    assign err_now    = stray_word || timed_out
                        || (word_ok && (state == ST_FILL) && !hdr_match);

    // Reads keep flowing while resynchronising so the stream can be scanned for a new start
    assign RD_EN = rst_n && ((state == ST_FILL) || (state == ST_RESYNC))
                   && !RD_EMPTY && !pending;

    always_comb begin
        store_en   = 1'b0;
        store_slot = recv_cnt;
        if (word_ok && (state == ST_FILL) && hdr_match) begin
            store_en = 1'b1;
        end else if (word_ok && ((state == ST_FILL) || (state == ST_RESYNC)) && hdr_index0) begin
            store_en   = 1'b1;
            store_slot = '0;
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            recv_cnt  <= '0;
            idle_cnt  <= '0;
            pending   <= 1'b0;
            ev_data   <= '1;
            ev_hits   <= '0;
            ev_valid  <= 1'b0;
            err_seq   <= 1'b0;
            err_count <= 8'd0;
        end else begin
            pending <= RD_EN ? 1'b1 : (RD_VALID ? 1'b0 : pending);
            err_seq <= err_now;
            if (err_now && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (store_en) begin
                ev_data[8*store_slot +: 8] <= radius;
                ev_hits[store_slot]        <= (radius != NO_HIT);
            end

            case (state)
                ST_FILL: begin
                    if (word_ok) begin
                        idle_cnt <= '0;
                        if (hdr_match) begin
                            if (recv_cnt == IDX_W'(WORDS_PER_EVENT - 1)) begin
                                state    <= ST_HOLD;
                                ev_valid <= 1'b1;
                            end else begin
                                recv_cnt <= recv_cnt + 1'b1;
                            end
                        end else if (hdr_index0) begin
                            recv_cnt <= IDX_W'(1);
                        end else begin
                            recv_cnt <= '0;
                            state    <= ST_RESYNC;
                        end
                    end else if (timed_out) begin
                        recv_cnt <= '0;
                        idle_cnt <= '0;
                    end else if (recv_cnt != '0) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (ev_valid && ev_ready) begin
                        ev_valid <= 1'b0;
                        recv_cnt <= '0;
                        idle_cnt <= '0;
                        state    <= ST_FILL;
                    end
                end
                ST_RESYNC: begin
                    if (word_ok && hdr_index0) begin
                        recv_cnt <= IDX_W'(1);
                        idle_cnt <= '0;
                        state    <= ST_FILL;
                    end
                end
                default: begin
                    recv_cnt <= '0;
                    idle_cnt <= '0;
                    state    <= ST_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_reader.sv
// tb/tb_event_reader.sv - randomized self-checking bench for event_reader against a word-list model
module tb_event_reader;

    localparam logic [4:0] CODES [4] = '{5'b11000, 5'b11001, 5'b00100, 5'b00101};

    logic         clk100 = 1'b0;
    logic         rst_n = 1'b0;
    logic         RD_EMPTY;
    logic         RD_VALID = 1'b0;
    logic [15:0]  OTUBE = 16'h0000;
    logic         RD_EN;
    logic [255:0] ev_data;
    logic [31:0]  ev_hits;
    logic         ev_valid;
    logic         ev_ready = 1'b0;
    logic         err_seq;
    logic [7:0]   err_count;

    always #5 clk100 = ~clk100;

    event_reader dut (
        .clk100    (clk100),
        .rst_n     (rst_n),
        .RD_EMPTY  (RD_EMPTY),
        .RD_VALID  (RD_VALID),
        .OTUBE     (OTUBE),
        .RD_EN     (RD_EN),
        .ev_data   (ev_data),
        .ev_hits   (ev_hits),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .err_seq   (err_seq),
        .err_count (err_count)
    );

    logic [15:0] fifo_mem [1024];
    int wr_ptr = 0, rd_ptr = 0, stray_req = 0, stray_done = 0;
    int cyc = 0, pulse_cnt = 0, err_cyc = 0, last_valid_cyc = 0;

    assign RD_EMPTY = (wr_ptr == rd_ptr);

    always @(posedge clk100) begin
        cyc <= cyc + 1;
        if (RD_EN && !RD_EMPTY) begin
            OTUBE    <= fifo_mem[rd_ptr % 1024];
            RD_VALID <= 1'b1;
            rd_ptr   <= rd_ptr + 1;
        end else if (stray_req != stray_done) begin
            OTUBE      <= 16'h5518;
            RD_VALID   <= 1'b1;
            stray_done <= stray_done + 1;
        end else begin
            RD_VALID <= 1'b0;
        end
    end

    always @(negedge clk100) begin
        if (RD_VALID) last_valid_cyc <= cyc;
        if (!rst_n) begin
            pulse_cnt <= 0;
        end else if (err_seq) begin
            pulse_cnt <= pulse_cnt + 1;
            err_cyc   <= cyc;
        end
    end

    int n_pass = 0, n_checks = 0;
    int m_cnt = 0, m_err = 0;
    bit m_resync = 0;
    logic [255:0] m_data = '1;
    logic [31:0]  m_hits = '0;
    logic [255:0] q_data [$];
    logic [31:0]  q_hits [$];
    logic [255:0] last_data;
    logic [31:0]  last_hits;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] mk(input int k, input logic [7:0] r);
        logic [2:0] t;
        t = 3'(k % 8);
        return {r, t, CODES[k / 8]};
    endfunction

    function automatic logic [7:0] rnd_radius();
        if ($urandom_range(0, 3) == 0) return 8'hFF;
        return 8'($urandom_range(0, 254));
    endfunction

    function automatic bit is_hdr(input logic [15:0] w, input int k);
        return (w[4:0] == CODES[k / 8]) && (w[7:5] == 3'(k % 8));
    endfunction

    task automatic m_store(input logic [15:0] w);
        m_data[8*m_cnt +: 8] = w[15:8];
        m_hits[m_cnt]        = (w[15:8] != 8'hFF);
        m_cnt++;
        if (m_cnt == 32) begin
            q_data.push_back(m_data);
            q_hits.push_back(m_hits);
            m_cnt = 0;
        end
    endtask

    // Event-level rules applied to the word stream in consumption order
    task automatic model_word(input logic [15:0] w);
        if (m_resync) begin
            if (is_hdr(w, 0)) begin
                m_resync = 0;
                m_cnt    = 0;
                m_store(w);
            end
        end else if (is_hdr(w, m_cnt)) begin
            m_store(w);
        end else begin
            m_err++;
            m_cnt = 0;
            if (is_hdr(w, 0)) m_store(w);
            else m_resync = 1;
        end
    endtask

    task automatic push_raw(input logic [15:0] w);
        fifo_mem[wr_ptr % 1024] = w;
        wr_ptr++;
    endtask

    task automatic push(input logic [15:0] w);
        push_raw(w);
        model_word(w);
    endtask

    task automatic wait_event(input string tag);
        int n;
        logic [255:0] exp_d;
        logic [31:0]  exp_h;
        n = 0;
        while (ev_valid !== 1'b1 && n < 4000) begin
            @(negedge clk100);
            n++;
        end
        chk({tag, "_seen"}, ev_valid, 1'b1);
        if (ev_valid === 1'b1) begin
            last_data = ev_data;
            last_hits = ev_hits;
            exp_d = (q_data.size() > 0) ? q_data.pop_front() : 'x;
            exp_h = (q_hits.size() > 0) ? q_hits.pop_front() : 'x;
            chk({tag, "_data"}, ev_data, exp_d);
            chk({tag, "_hits"}, ev_hits, exp_h);
            ev_ready = 1'b1;
            @(negedge clk100);
            chk({tag, "_handshake"}, ev_valid, 1'b0);
        end
    endtask

    initial begin
        logic [255:0] snap;
        logic [255:0] ramp;
        bit rd_bad, data_bad, valid_bad;
        int n, p0, base;

        rst_n = 1'b0;
        ev_ready = 1'b0;
        repeat (3) @(negedge clk100);
        chk("rst_rd_en", RD_EN, 1'b0);
        chk("rst_ev_valid", ev_valid, 1'b0);
        chk("rst_ev_data", ev_data, {256{1'b1}});
        chk("rst_ev_hits", ev_hits, 32'h0);
        chk("rst_err_seq", err_seq, 1'b0);
        chk("rst_err_count", err_count, 8'd0);
        rst_n = 1'b1;
        ev_ready = 1'b1;
        @(negedge clk100);

        // ordered ramp: slot k holds k
        for (int k = 0; k < 32; k++) begin
            push(mk(k, 8'(k)));
            ramp[8*k +: 8] = 8'(k);
        end
        wait_event("ramp");
        chk("ramp_slots", last_data, ramp);
        chk("ramp_hits_all", last_hits, 32'hFFFFFFFF);
        chk("ramp_err_count", err_count, 8'd0);

        // single hit in slot 9
        for (int k = 0; k < 32; k++) push(mk(k, (k == 9) ? 8'h2A : 8'hFF));
        wait_event("single");
        chk("single_hits", last_hits, 32'h0000_0200);
        chk("single_slot9", last_data[79:72], 8'h2A);

        // consumer stalls with more words already queued
        ev_ready = 1'b0;
        for (int k = 0; k < 32; k++) push(mk(k, rnd_radius()));
        for (int k = 0; k < 8; k++) push(mk(k, rnd_radius()));
        n = 0;
        while (ev_valid !== 1'b1 && n < 4000) begin
            @(negedge clk100);
            n++;
        end
        chk("hold_seen", ev_valid, 1'b1);
        snap = ev_data;
        rd_bad = 0; data_bad = 0; valid_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk100);
            if (RD_EN !== 1'b0) rd_bad = 1;
            if (ev_data !== snap) data_bad = 1;
            if (ev_valid !== 1'b1) valid_bad = 1;
        end
        chk("hold_rd_en_low", rd_bad, 1'b0);
        chk("hold_data_stable", data_bad, 1'b0);
        chk("hold_valid_held", valid_bad, 1'b0);
        chk("hold_fifo_nonempty", RD_EMPTY, 1'b0);
        chk("hold_data", snap, (q_data.size() > 0) ? q_data.pop_front() : 'x);
        chk("hold_hits", ev_hits, (q_hits.size() > 0) ? q_hits.pop_front() : 'x);
        ev_ready = 1'b1;
        @(negedge clk100);
        chk("hold_release", ev_valid, 1'b0);
        for (int k = 8; k < 32; k++) push(mk(k, rnd_radius()));
        wait_event("after_hold");
        chk("after_hold_err", err_count, 8'd0);

        // bad header at word 5, then a clean restart
        for (int k = 0; k < 5; k++) push(mk(k, rnd_radius()));
        push({8'h33, 3'b011, 5'b00100});
        for (int k = 0; k < 32; k++) push(mk(k, rnd_radius()));
        wait_event("seq_err");
        chk("seq_err_pulses", pulse_cnt, 1);
        chk("seq_err_count", err_count, 8'd1);

        // partial event abandoned by the source
        for (int k = 0; k < 10; k++) push(mk(k, rnd_radius()));
        n = 0;
        while (rd_ptr != wr_ptr && n < 200) begin
            @(negedge clk100);
            n++;
        end
        repeat (3) @(negedge clk100);
        p0 = pulse_cnt;
        n = 0;
        while (pulse_cnt == p0 && n < 1500) begin
            @(negedge clk100);
            n++;
        end
        if (m_cnt > 0) begin
            m_err++;
            m_cnt = 0;
        end
        chk("timeout_pulses", pulse_cnt, m_err);
        chk("timeout_delay", err_cyc - last_valid_cyc, 1025);
        chk("timeout_err_count", err_count, 8'(m_err));
        for (int k = 0; k < 32; k++) push(mk(k, rnd_radius()));
        wait_event("after_timeout");

        // unsolicited read data, through to saturation
        repeat (5) @(negedge clk100);
        for (int i = 0; i < 260; i++) begin
            stray_req++;
            m_err++;
            repeat (3) @(negedge clk100);
            if (i == 0) chk("stray_first", err_count, 8'(m_err));
        end
        repeat (3) @(negedge clk100);
        chk("stray_pulses", pulse_cnt, m_err);
        chk("stray_saturate", err_count, 8'hFF);

        // reset in the middle of an event
        base = rd_ptr;
        for (int k = 0; k < 32; k++) push_raw(mk(k, rnd_radius()));
        n = 0;
        while (rd_ptr - base < 20 && n < 400) begin
            @(negedge clk100);
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk100);
        chk("mid_rst_rd_en", RD_EN, 1'b0);
        chk("mid_rst_ev_valid", ev_valid, 1'b0);
        chk("mid_rst_ev_data", ev_data, {256{1'b1}});
        chk("mid_rst_ev_hits", ev_hits, 32'h0);
        chk("mid_rst_err_count", err_count, 8'd0);
        wr_ptr = rd_ptr;
        repeat (2) @(negedge clk100);
        rst_n = 1'b1;
        m_cnt = 0; m_resync = 0; m_err = 0;
        q_data.delete();
        q_hits.delete();
        @(negedge clk100);
        for (int k = 0; k < 32; k++) push(mk(k, rnd_radius()));
        wait_event("after_reset");
        chk("after_reset_err_le1", (err_count <= 8'd1), 1'b1);
        chk("after_reset_err_pulses", err_count, 8'(pulse_cnt));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
